// File: rtl/piso_tx_8bit_if.sv
// piso_tx_8bit_if: word-load handshake and framed serial output of piso_tx_8bit.
interface piso_tx_8bit_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] D;
  logic load_valid;
  logic load_ready;
  logic sout;
  logic sout_valid;
  logic frame_start;
  logic frame_end;
  logic busy;
  modport master(output D, load_valid, input load_ready, sout, sout_valid, frame_start, frame_end, busy);
  modport slave(input D, load_valid, output load_ready, sout, sout_valid, frame_start, frame_end, busy);
endinterface

// File: rtl/piso_tx_8bit.sv
// piso_tx_8bit: valid/ready parallel-in serial-out transmitter with framing strobes.
// Define PIRO_TX_PARITY_EN to append an even-parity bit to every frame.
module piso_tx_8bit #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 0
) (
  input logic clk,
  input logic clear,
  piso_tx_8bit_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
`ifdef PIRO_TX_PARITY_EN
  localparam logic [1:0] PAR = 2'd2;
  logic r_par;
`else
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);
`endif
  logic [1:0] r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0] r_cnt;
  logic r_sout;
  logic r_sv;
  logic r_fs;
  logic r_fe;
  logic w_last;
  logic w_accept;
  logic w_load_first;
  logic w_shift_first;
  logic [WIDTH-1:0] w_load_rest;
  logic [WIDTH-1:0] w_shift_rest;
  always_comb begin
    w_last = r_state == SHIFT && r_cnt == LAST;
`ifdef PIRO_TX_PARITY_EN
    bus.load_ready = r_state == IDLE || r_state == PAR;
`else
    bus.load_ready = r_state == IDLE || w_last;
`endif
    w_accept = bus.load_valid && bus.load_ready;
    w_load_first = MSB_FIRST ? bus.D[WIDTH-1] : bus.D[0];
    w_load_rest = MSB_FIRST ? bus.D << 1 : bus.D >> 1;
    w_shift_first = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
    w_shift_rest = MSB_FIRST ? r_shift << 1 : r_shift >> 1;
  end
  // The first bit goes straight to sout on acceptance; r_shift holds only the bits still to send.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt <= '0;
      r_sout <= 1'b0;
      r_sv <= 1'b0;
      r_fs <= 1'b0;
      r_fe <= 1'b0;
`ifdef PIRO_TX_PARITY_EN
      r_par <= 1'b0;
`endif
    end else if (w_accept) begin
      r_state <= SHIFT;
      r_shift <= w_load_rest;
      r_cnt <= '0;
      r_sout <= w_load_first;
      r_sv <= 1'b1;
      r_fs <= 1'b1;
      r_fe <= 1'b0;
`ifdef PIRO_TX_PARITY_EN
      r_par <= ^bus.D;
`endif
    end else if (r_state == SHIFT && !w_last) begin
      r_shift <= w_shift_rest;
      r_cnt <= r_cnt + 1'b1;
      r_sout <= w_shift_first;
      r_fs <= 1'b0;
`ifdef PIRO_TX_PARITY_EN
      r_fe <= 1'b0;
    end else if (w_last) begin
      r_state <= PAR;
      r_sout <= r_par;
      r_fs <= 1'b0;
      r_fe <= 1'b1;
`else
      r_fe <= r_cnt == PENULT;
`endif
    end else begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt <= '0;
      r_sout <= 1'b0;
      r_sv <= 1'b0;
      r_fs <= 1'b0;
      r_fe <= 1'b0;
    end
  end
  assign bus.sout = r_sout;
  assign bus.sout_valid = r_sv;
  assign bus.frame_start = r_fs;
  assign bus.frame_end = r_fe;
  assign bus.busy = r_sv;
endmodule

// File: tb/tb_piso_tx_8bit.sv
// tb_piso_tx_8bit: directed checks of LSB-first and MSB-first instances driven in parallel.
module tb_piso_tx_8bit;
`ifdef PIRO_TX_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif
  localparam int FL = HAS_PAR ? 9 : 8;
  logic clk = 1'b0;
  logic clear = 1'b1;
  logic [7:0] d = 8'h00;
  logic v = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  piso_tx_8bit_if #(.WIDTH(8)) bl();
  piso_tx_8bit_if #(.WIDTH(8)) bm();
  assign bl.D = d;
  assign bl.load_valid = v;
  assign bm.D = d;
  assign bm.load_valid = v;
  piso_tx_8bit #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .clear(clear), .bus(bl));
  piso_tx_8bit #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .clear(clear), .bus(bm));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle_chk(input string tag);
    v = 1'b0;
    chk({tag, " sout"}, bl.sout, 0);
    chk({tag, " sv"}, bl.sout_valid, 0);
    chk({tag, " fs"}, bl.frame_start, 0);
    chk({tag, " fe"}, bl.frame_end, 0);
    chk({tag, " busy"}, bl.busy, 0);
    chk({tag, " rdy"}, bl.load_ready, 1);
    chk({tag, " msb sv"}, bm.sout_valid, 0);
    chk({tag, " msb sout"}, bm.sout, 0);
  endtask
  task automatic send(input string tag, input logic [7:0] w);
    d = w;
    v = 1'b1;
    chk({tag, " accept rdy"}, bl.load_ready, 1);
    tick();
  endtask
  // Called on cycle 1 of a frame; holds load_valid with word nd during cycles lo..hi.
  task automatic check_frame(input string tag, input logic [7:0] w, input int lo, input int hi, input logic [7:0] nd);
    logic el;
    logic em;
    for (int k = 1; k <= FL; k++) begin
      v = (k >= lo && k <= hi);
      if (v) d = nd;
      el = (k <= 8) ? w[k-1] : ^w;
      em = (k <= 8) ? w[8-k] : ^w;
      chk($sformatf("%s c%0d sout", tag, k), bl.sout, el);
      chk($sformatf("%s c%0d msb sout", tag, k), bm.sout, em);
      chk($sformatf("%s c%0d sv", tag, k), bl.sout_valid, 1);
      chk($sformatf("%s c%0d busy", tag, k), bl.busy, 1);
      chk($sformatf("%s c%0d fs", tag, k), bl.frame_start, k == 1);
      chk($sformatf("%s c%0d fe", tag, k), bl.frame_end, k == FL);
      chk($sformatf("%s c%0d msb fe", tag, k), bm.frame_end, k == FL);
      chk($sformatf("%s c%0d rdy", tag, k), bl.load_ready, k == FL);
      tick();
    end
  endtask
  initial begin
    tick();
    tick();
    chk("rst sout", bl.sout, 0);
    chk("rst sv", bl.sout_valid, 0);
    chk("rst fs", bl.frame_start, 0);
    chk("rst fe", bl.frame_end, 0);
    chk("rst busy", bl.busy, 0);
    chk("rst msb sv", bm.sout_valid, 0);
    clear = 1'b0;
    send("a5", 8'hA5);
    check_frame("a5", 8'hA5, 1, 0, 8'h00);
    idle_chk("a5 end");
    send("c1", 8'hC1);
    check_frame("c1", 8'hC1, 1, 0, 8'h00);
    idle_chk("c1 end");
    send("b2b", 8'hA5);
    check_frame("b2b1", 8'hA5, 1, FL, 8'h3C);
    check_frame("b2b2", 8'h3C, 1, 0, 8'h00);
    idle_chk("b2b end");
    send("ff", 8'hFF);
    for (int k = 1; k <= 3; k++) begin
      v = 1'b0;
      chk($sformatf("ff c%0d sout", k), bl.sout, 1);
      chk($sformatf("ff c%0d sv", k), bl.sout_valid, 1);
      tick();
    end
    clear = 1'b1;
    d = 8'h55;
    v = 1'b1;
    tick();
    v = 1'b0;
    clear = 1'b0;
    idle_chk("clr c5");
    tick();
    idle_chk("clr c6");
    send("01", 8'h01);
    check_frame("01", 8'h01, 1, 0, 8'h00);
    idle_chk("01 end");
    send("hold", 8'hA5);
    check_frame("hold", 8'hA5, 2, 6, 8'h00);
    idle_chk("hold end");
    send("07", 8'h07);
    check_frame("07", 8'h07, 1, 0, 8'h00);
    idle_chk("07 end");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
